falafel_req_arbiter: RTL and testbench
======================================

Name: falafel_req_arbiter

Overview:
Shares one falafel_core allocator between NUM_REQ independent clients, such as CPU ports and DMA engines. Clients issue alloc or free requests on per-port valid/ready handshakes. The block grants one request at a time in round-robin order, drives the core's request interface, waits for completion, and returns the result to the granted client. It also rejects zero-size allocs locally and flags core hangs with a watchdog.

Parameters:
NUM_REQ, 4, number of client ports (2..16).
TIMEOUT_CYCLES, 1024, WAIT_DONE cycles before timeout_o asserts.
IDX_W, $clog2(NUM_REQ), grant index width (derived; not overridden).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
cl_req_valid_i  in  NUM_REQ  per-client request valid
cl_req_ready_o  out  NUM_REQ  per-client accept, one-hot or zero
cl_is_alloc_i  in  NUM_REQ  1 = alloc, 0 = free
cl_size_i  in  NUM_REQ*DATA_W  alloc size per client
cl_addr_i  in  NUM_REQ*DATA_W  free address per client
cl_rsp_valid_o  out  NUM_REQ  per-client response valid, one-hot or zero
cl_rsp_ready_i  in  NUM_REQ  per-client response accept
cl_rsp_addr_o  out  DATA_W  result address, shared bus, meaningful only with rsp_valid
cl_rsp_err_o  out  1  request rejected; shared bus
core_req_valid_o  out  1  to core req_alloc_valid_i
core_is_alloc_o  out  1  to core is_alloc_i
core_size_o  out  DATA_W  to core size_to_allocate_i
core_addr_o  out  DATA_W  to core addr_to_free_i
core_ready_i  in  1  from core core_ready_o
core_done_i  in  1  one-cycle completion pulse from core
core_result_i  in  DATA_W  allocated block address, valid with core_done_i
grant_idx_o  out  IDX_W  currently granted client, for debug
busy_o  out  1  high in every state except IDLE
timeout_o  out  1  watchdog flag

Behaviour:
- Reset (rst_i high at a clock edge): state = IDLE, rr_ptr = 0, grant = 0, wd_cnt = 0, and all latched payload/result registers cleared. All outputs are 0.
- Reset mid-operation aborts unconditionally. No response is returned. The core must be reset in the same cycle.
- State machine: IDLE -> ISSUE -> WAIT_DONE -> RESPOND -> IDLE. A rejected request goes IDLE -> RESPOND.
- IDLE:
  - grant = first set bit of cl_req_valid_i, searching upward from rr_ptr and wrapping modulo NUM_REQ.
  - In the same cycle, cl_req_ready_o[grant] = 1 (combinational), and is_alloc, size and addr are latched from slice grant.
  - If is_alloc = 1 and size = 0: res_err = 1, res_addr = 0, next state RESPOND.
  - Otherwise, next state ISSUE.
  - With no valid requests, stay in IDLE and drive all readies to 0.
- ISSUE:
  - core_req_valid_o = 1; core_is_alloc_o, core_size_o and core_addr_o carry the latched payload. These core outputs are 0 in every other state.
  - Handshake occurs when core_ready_i = 1 in the same cycle. Then wd_cnt = 0 and next state is WAIT_DONE.
  - Otherwise, hold all outputs stable.
- WAIT_DONE:
  - wd_cnt increments each cycle and saturates at TIMEOUT_CYCLES.
  - timeout_o = 1 while wd_cnt == TIMEOUT_CYCLES. The block keeps waiting; there is no abort.
  - On core_done_i: latch res_addr = core_result_i, res_err = 0, next state RESPOND.
  - For a free request, core_result_i is ignored and res_addr = 0.
- RESPOND:
  - cl_rsp_valid_o[grant] = 1, cl_rsp_addr_o = res_addr, cl_rsp_err_o = res_err, all held stable.
  - On cl_rsp_ready_i[grant]: rr_ptr = (grant + 1) mod NUM_REQ, next state IDLE.
  - The earliest next grant is the following cycle, so there is no back-to-back accept in the RESPOND cycle.
- Boundary rules:
  - core_done_i outside WAIT_DONE is ignored.
  - A client that deasserts valid while not granted loses nothing; the next grant uses the updated vector.
  - Ready inputs of non-granted clients are ignored.
  - Wrap: with rr_ptr = NUM_REQ-1 and only client 0 valid, grant = 0.
  - Latency: accept -> core_req_valid_o is 1 cycle; core_done_i -> cl_rsp_valid_o is 1 cycle.
  - Rejected request: accept -> rsp_valid is 1 cycle.
- Only one request is outstanding at a time; the core's internal lock is not relied on for mutual exclusion.

Decomposition:
- Add the arb_state_e enum and DEFAULT_TIMEOUT_CYCLES to falafel_pkg; reuse DATA_W from there.
- Sub-module rr_picker: combinational round-robin first-one finder, taking valid[NUM_REQ] and ptr[IDX_W] and producing idx[IDX_W] and any.
- The FSM, payload/result registers and watchdog counter live in the top module.

Test Plan:
- Single client 2 requests alloc size 0x40; core acks after 3 cycles and pulses done with result 0x50 -> cl_rsp_valid_o = 0b0100, addr 0x50, err 0; rr_ptr becomes 3.
- All 4 clients valid continuously from reset -> grants in order 0,1,2,3,0; each client's core payload appears on core_size_o exactly once per round.
- Client 1 alloc size 0 -> core_req_valid_o never rises; rsp on client 1 one cycle after accept with err = 1, addr = 0.
- Core holds core_ready_i = 0 for 5 cycles in ISSUE -> core_req_valid_o and payload stay stable all 5 cycles; the handshake completes on cycle 6.
- TIMEOUT_CYCLES = 8, core never pulses done -> timeout_o rises 8 cycles after the handshake and stays high; a later done clears it via RESPOND/IDLE with err = 0.
- Free request addr 0x200 from client 3 with rsp_ready held low for 4 cycles -> rsp_valid, addr 0 and err 0 held stable; a done pulse injected during RESPOND is ignored; rst_i asserted in WAIT_DONE -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/falafel_pkg.sv
// Shared definitions for the falafel allocator and its request arbiter.
package falafel_pkg;

  localparam int DATA_W                 = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_DONE = 2'd2,
    ARB_RESPOND   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/falafel_req_arbiter_rr_picker.sv
// Combinational round-robin first-one finder: returns the first set bit of
// valid, searching upward from ptr and wrapping modulo NUM_REQ.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan every client once, starting at ptr; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // a variable unassigned and no latch is inferred.
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int pos;
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!any && valid[pos]) begin
        idx = pos[IDX_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/falafel_req_arbiter.sv
// Round-robin arbiter sharing one falafel_core allocator between NUM_REQ
// clients. One request is outstanding at a time; zero-size allocs are
// rejected locally and a watchdog flags a core that never completes.
module falafel_req_arbiter
  import falafel_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        cl_req_valid_i,
  output logic [NUM_REQ-1:0]        cl_req_ready_o,
  input  logic [NUM_REQ-1:0]        cl_is_alloc_i,
  input  logic [NUM_REQ*DATA_W-1:0] cl_size_i,
  input  logic [NUM_REQ*DATA_W-1:0] cl_addr_i,
  output logic [NUM_REQ-1:0]        cl_rsp_valid_o,
  input  logic [NUM_REQ-1:0]        cl_rsp_ready_i,
  output logic [DATA_W-1:0]         cl_rsp_addr_o,
  output logic                      cl_rsp_err_o,
  output logic                      core_req_valid_o,
  output logic                      core_is_alloc_o,
  output logic [DATA_W-1:0]         core_size_o,
  output logic [DATA_W-1:0]         core_addr_o,
  input  logic                      core_ready_i,
  input  logic                      core_done_i,
  input  logic [DATA_W-1:0]         core_result_i,
  output logic [IDX_W-1:0]          grant_idx_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e        state, state_d;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant;
  logic [WD_W-1:0]   wd_cnt;
  logic              lat_is_alloc;
  logic [DATA_W-1:0] lat_size;
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] res_addr;
  logic              res_err;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               sel_is_alloc;
  logic [DATA_W-1:0]  sel_size;
  logic [DATA_W-1:0]  sel_addr;
  logic               accept;
  logic               reject;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] grant_oh;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid (cl_req_valid_i),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_is_alloc = cl_is_alloc_i[pick_idx];
  assign sel_size     = cl_size_i[int'(pick_idx)*DATA_W +: DATA_W];
  assign sel_addr     = cl_addr_i[int'(pick_idx)*DATA_W +: DATA_W];
  // Accept is suppressed while reset is held so nothing is consumed then.
  assign accept       = (state == ARB_IDLE) && pick_any && !rst_i;
  assign reject       = sel_is_alloc && (sel_size == '0);

  assign grant_idx_o = grant;
  assign busy_o      = (state != ARB_IDLE);
  assign timeout_o   = (state == ARB_WAIT_DONE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  // One-hot decodes of the candidate and the latched grant.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      pick_oh[k]  = (k == int'(pick_idx));
      grant_oh[k] = (k == int'(grant));
    end
  end

  // Next-state logic and all handshake outputs of the arbiter FSM.
  always_comb begin
    state_d          = state;
    cl_req_ready_o   = '0;
    cl_rsp_valid_o   = '0;
    cl_rsp_addr_o    = '0;
    cl_rsp_err_o     = 1'b0;
    core_req_valid_o = 1'b0;
    core_is_alloc_o  = 1'b0;
    core_size_o      = '0;
    core_addr_o      = '0;
    case (state)
      ARB_IDLE: begin
        if (accept) begin
          cl_req_ready_o = pick_oh;
          state_d        = reject ? ARB_RESPOND : ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        core_req_valid_o = 1'b1;
        core_is_alloc_o  = lat_is_alloc;
        core_size_o      = lat_size;
        core_addr_o      = lat_addr;
        if (core_ready_i) state_d = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        if (core_done_i) state_d = ARB_RESPOND;
      end
      ARB_RESPOND: begin
        cl_rsp_valid_o = grant_oh;
        cl_rsp_addr_o  = res_addr;
        cl_rsp_err_o   = res_err;
        if (cl_rsp_ready_i[grant]) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, grant pointer, latched payload/result and watchdog registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before this edge, independent of statement order.
    if (rst_i) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      wd_cnt       <= '0;
      lat_is_alloc <= 1'b0;
      lat_size     <= '0;
      lat_addr     <= '0;
      res_addr     <= '0;
      res_err      <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        ARB_IDLE: begin
          if (accept) begin
            grant        <= pick_idx;
            lat_is_alloc <= sel_is_alloc;
            lat_size     <= sel_size;
            lat_addr     <= sel_addr;
            if (reject) begin
              res_err  <= 1'b1;
              res_addr <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          if (core_ready_i) wd_cnt <= '0;
        end
        ARB_WAIT_DONE: begin
          if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + WD_W'(1);
          if (core_done_i) begin
            res_addr <= lat_is_alloc ? core_result_i : '0;
            res_err  <= 1'b0;
          end
        end
        ARB_RESPOND: begin
          if (cl_rsp_ready_i[grant])
            rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// Directed self-checking bench for falafel_req_arbiter (4 clients,
// watchdog shortened to 8 cycles).
module tb_falafel_req_arbiter;
  import falafel_pkg::*;

  localparam int N  = 4;
  localparam int DW = DATA_W;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    cl_req_valid_i = '0;
  logic [N-1:0]    cl_req_ready_o;
  logic [N-1:0]    cl_is_alloc_i = '0;
  logic [N*DW-1:0] cl_size_i = '0;
  logic [N*DW-1:0] cl_addr_i = '0;
  logic [N-1:0]    cl_rsp_valid_o;
  logic [N-1:0]    cl_rsp_ready_i = '0;
  logic [DW-1:0]   cl_rsp_addr_o;
  logic            cl_rsp_err_o;
  logic            core_req_valid_o;
  logic            core_is_alloc_o;
  logic [DW-1:0]   core_size_o;
  logic [DW-1:0]   core_addr_o;
  logic            core_ready_i = 1'b0;
  logic            core_done_i = 1'b0;
  logic [DW-1:0]   core_result_i = '0;
  logic [1:0]      grant_idx_o;
  logic            busy_o;
  logic            timeout_o;

  int n_total = 0;
  int n_bad   = 0;

  falafel_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cl_req_valid_i   (cl_req_valid_i),
    .cl_req_ready_o   (cl_req_ready_o),
    .cl_is_alloc_i    (cl_is_alloc_i),
    .cl_size_i        (cl_size_i),
    .cl_addr_i        (cl_addr_i),
    .cl_rsp_valid_o   (cl_rsp_valid_o),
    .cl_rsp_ready_i   (cl_rsp_ready_i),
    .cl_rsp_addr_o    (cl_rsp_addr_o),
    .cl_rsp_err_o     (cl_rsp_err_o),
    .core_req_valid_o (core_req_valid_o),
    .core_is_alloc_o  (core_is_alloc_o),
    .core_size_o      (core_size_o),
    .core_addr_o      (core_addr_o),
    .core_ready_i     (core_ready_i),
    .core_done_i      (core_done_i),
    .core_result_i    (core_result_i),
    .grant_idx_o      (grant_idx_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int c, input logic alloc, input logic [DW-1:0] sz,
                         input logic [DW-1:0] ad);
    cl_req_valid_i[c]       = 1'b1;
    cl_is_alloc_i[c]        = alloc;
    cl_size_i[c*DW +: DW]   = sz;
    cl_addr_i[c*DW +: DW]   = ad;
  endtask

  task automatic do_reset();
    rst_i          = 1'b1;
    cl_req_valid_i = '0;
    cl_rsp_ready_i = '0;
    core_ready_i   = 1'b0;
    core_done_i    = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  // Full alloc transaction for the client expected to win the next grant.
  task automatic serve(input string tag, input int c, input logic [DW-1:0] exp_size,
                       input logic [DW-1:0] result);
    logic [N-1:0] oh;
    oh = '0;
    oh[c] = 1'b1;
    check({tag, "_ready"}, 64'(cl_req_ready_o), 64'(oh));
    tick();
    check({tag, "_core_valid"}, 64'(core_req_valid_o), 64'd1);
    check({tag, "_core_size"}, 64'(core_size_o), 64'(exp_size));
    check({tag, "_grant"}, 64'(grant_idx_o), 64'(c));
    core_ready_i = 1'b1;
    tick();
    core_ready_i  = 1'b0;
    core_done_i   = 1'b1;
    core_result_i = result;
    tick();
    core_done_i = 1'b0;
    check({tag, "_rsp_valid"}, 64'(cl_rsp_valid_o), 64'(oh));
    check({tag, "_rsp_addr"}, 64'(cl_rsp_addr_o), 64'(result));
    check({tag, "_rsp_err"}, 64'(cl_rsp_err_o), 64'd0);
    check({tag, "_no_b2b"}, 64'(cl_req_ready_o), 64'd0);
    cl_rsp_ready_i = '1;
    tick();
    cl_rsp_ready_i = '0;
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    check("rst_ready", 64'(cl_req_ready_o), 64'd0);
    check("rst_rsp_valid", 64'(cl_rsp_valid_o), 64'd0);
    check("rst_core_valid", 64'(core_req_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_grant", 64'(grant_idx_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);

    // ---------------- single client 2, delayed core ack ----------------
    set_req(2, 1'b1, 32'h40, 32'h0);
    #1;
    check("t1_ready", 64'(cl_req_ready_o), 64'b0100);
    tick();
    cl_req_valid_i = '0;
    check("t1_core_valid", 64'(core_req_valid_o), 64'd1);
    check("t1_core_size", 64'(core_size_o), 64'h40);
    check("t1_core_alloc", 64'(core_is_alloc_o), 64'd1);
    check("t1_busy", 64'(busy_o), 64'd1);
    tick();
    tick();
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    check("t1_wait_core_valid", 64'(core_req_valid_o), 64'd0);
    core_done_i   = 1'b1;
    core_result_i = 32'h50;
    tick();
    core_done_i = 1'b0;
    check("t1_rsp_valid", 64'(cl_rsp_valid_o), 64'b0100);
    check("t1_rsp_addr", 64'(cl_rsp_addr_o), 64'h50);
    check("t1_rsp_err", 64'(cl_rsp_err_o), 64'd0);
    cl_rsp_ready_i = 4'b0100;
    tick();
    cl_rsp_ready_i = '0;
    // rr_ptr is now 3: client 3 beats client 0.
    set_req(0, 1'b1, 32'h11, 32'h0);
    set_req(3, 1'b1, 32'h33, 32'h0);
    #1;
    check("t1_rrptr3", 64'(cl_req_ready_o), 64'b1000);
    // Wrap: rr_ptr = 3, only client 0 valid -> grant 0.
    cl_req_valid_i = 4'b0001;
    #1;
    check("t1_wrap", 64'(cl_req_ready_o), 64'b0001);
    cl_req_valid_i = '0;

    // ---------------- all clients valid, round robin ----------------
    do_reset();
    set_req(0, 1'b1, 32'h10, 32'h0);
    set_req(1, 1'b1, 32'h20, 32'h0);
    set_req(2, 1'b1, 32'h30, 32'h0);
    set_req(3, 1'b1, 32'h40, 32'h0);
    #1;
    serve("rr0", 0, 32'h10, 32'h1000);
    serve("rr1", 1, 32'h20, 32'h2000);
    serve("rr2", 2, 32'h30, 32'h3000);
    serve("rr3", 3, 32'h40, 32'h4000);
    serve("rr4", 0, 32'h10, 32'h5000);
    cl_req_valid_i = '0;

    // ---------------- zero-size alloc reject ----------------
    do_reset();
    set_req(1, 1'b1, 32'h0, 32'h0);
    #1;
    check("t3_ready", 64'(cl_req_ready_o), 64'b0010);
    tick();
    cl_req_valid_i = '0;
    check("t3_core_valid", 64'(core_req_valid_o), 64'd0);
    check("t3_rsp_valid", 64'(cl_rsp_valid_o), 64'b0010);
    check("t3_rsp_err", 64'(cl_rsp_err_o), 64'd1);
    check("t3_rsp_addr", 64'(cl_rsp_addr_o), 64'd0);
    cl_rsp_ready_i = 4'b0010;
    tick();
    cl_rsp_ready_i = '0;
    check("t3_idle", 64'(busy_o), 64'd0);

    // ---------------- stalled core ready, then watchdog ----------------
    do_reset();
    set_req(0, 1'b1, 32'h80, 32'h0);
    #1;
    tick();
    cl_req_valid_i = '0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_hold_valid%0d", i), 64'(core_req_valid_o), 64'd1);
      check($sformatf("t4_hold_size%0d", i), 64'(core_size_o), 64'h80);
      tick();
    end
    core_ready_i = 1'b1;
    check("t4_cycle6_valid", 64'(core_req_valid_o), 64'd1);
    tick();
    core_ready_i = 1'b0;
    check("t4_handshake_done", 64'(core_req_valid_o), 64'd0);
    check("t5_timeout_early", 64'(timeout_o), 64'd0);
    for (int i = 0; i < 7; i++) tick();
    check("t5_timeout_7", 64'(timeout_o), 64'd0);
    tick();
    check("t5_timeout_8", 64'(timeout_o), 64'd1);
    tick();
    tick();
    check("t5_timeout_hold", 64'(timeout_o), 64'd1);
    core_done_i   = 1'b1;
    core_result_i = 32'h900;
    tick();
    core_done_i = 1'b0;
    check("t5_rsp_valid", 64'(cl_rsp_valid_o), 64'b0001);
    check("t5_rsp_err", 64'(cl_rsp_err_o), 64'd0);
    check("t5_rsp_addr", 64'(cl_rsp_addr_o), 64'h900);
    check("t5_timeout_clear", 64'(timeout_o), 64'd0);
    cl_rsp_ready_i = 4'b0001;
    tick();
    cl_rsp_ready_i = '0;

    // ---------------- free request, held response, reset in WAIT ----------------
    do_reset();
    set_req(3, 1'b0, 32'h0, 32'h200);
    #1;
    tick();
    cl_req_valid_i = '0;
    check("t6_core_alloc", 64'(core_is_alloc_o), 64'd0);
    check("t6_core_addr", 64'(core_addr_o), 64'h200);
    core_ready_i = 1'b1;
    tick();
    core_ready_i  = 1'b0;
    core_done_i   = 1'b1;
    core_result_i = 32'hDEAD;
    tick();
    core_done_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_rsp_valid%0d", i), 64'(cl_rsp_valid_o), 64'b1000);
      check($sformatf("t6_rsp_addr%0d", i), 64'(cl_rsp_addr_o), 64'd0);
      check($sformatf("t6_rsp_err%0d", i), 64'(cl_rsp_err_o), 64'd0);
      cl_rsp_ready_i = 4'b0111;
      core_done_i    = (i == 1);
      core_result_i  = 32'h1234;
      tick();
      core_done_i = 1'b0;
    end
    check("t6_stray_done", 64'(cl_rsp_addr_o), 64'd0);
    cl_rsp_ready_i = 4'b1000;
    tick();
    cl_rsp_ready_i = '0;
    check("t6_idle", 64'(busy_o), 64'd0);
    set_req(3, 1'b1, 32'h44, 32'h0);
    #1;
    tick();
    cl_req_valid_i = '0;
    core_ready_i   = 1'b1;
    tick();
    core_ready_i = 1'b0;
    check("t6_in_wait", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    tick();
    check("t6_rst_busy", 64'(busy_o), 64'd0);
    check("t6_rst_core_valid", 64'(core_req_valid_o), 64'd0);
    check("t6_rst_rsp_valid", 64'(cl_rsp_valid_o), 64'd0);
    check("t6_rst_grant", 64'(grant_idx_o), 64'd0);
    check("t6_rst_ready", 64'(cl_req_ready_o), 64'd0);
    rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
